// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
// Frame sequencer for the serial single-bin DFT core and its twiddle ROMs.
// Samples arrive over a valid/ready stream. Each accepted sample is registered
// toward the core, and the twiddle ROM address is advanced so that the
// one-cycle-latency ROM output lines up with core_x_o. The first and last
// sample of every frame are flagged. After the last sample the controller
// waits for the core result and places it in a one-deep output buffer that
// has its own valid/ready handshake.
//
// Optional feature, enabled by defining FFT_FRAME_CTRL_TIMEOUT_EN:
//   A counter runs while the controller waits for the core. If TMO_CYCLES
//   wait cycles pass without core_valid_i, timeout_o is set (sticky) and
//   the controller returns to accepting samples. When the macro is
//   undefined, the wait lasts indefinitely and timeout_o is tied to 0.
//
// Ports:
//   clk, arstn        clock (rising edge), asynchronous active-low reset
//   s_valid_i/s_ready_o/s_x_i
//                     input sample stream, channel 0 in the LSBs
//   rom_addr_o        twiddle ROM address, shared by both ROMs
//   core_valid_o/core_x_o/core_first_o/core_last_o
//                     registered sample and frame markers to the core
//   core_valid_i/core_re_i/core_im_i
//                     result pulse and result data from the core
//   m_valid_o/m_ready_i/m_re_o/m_im_o
//                     buffered result stream
//   frame_cnt_o       number of completed frames, wraps at 16 bits
//   overrun_o         sticky: a core result was lost
//   timeout_o         sticky: the core did not respond (optional feature)
module fft_frame_ctrl #(
  parameter int X_WIDTH      = 16,
  parameter int S_WIDTH      = 32,
  parameter int FRAME_LENGTH = 10,
  parameter int CHANELS      = 2,
  parameter int CORE_LAT     = 2,
  parameter int TMO_CYCLES   = 16,
  localparam int ADDR_W      = $clog2(FRAME_LENGTH)
) (
  input  logic                         clk,
  input  logic                         arstn,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [CHANELS*X_WIDTH-1:0]   s_x_i,
  output logic [ADDR_W-1:0]            rom_addr_o,
  output logic                         core_valid_o,
  output logic [CHANELS*X_WIDTH-1:0]   core_x_o,
  output logic                         core_first_o,
  output logic                         core_last_o,
  input  logic                         core_valid_i,
  input  logic [CHANELS*S_WIDTH-1:0]   core_re_i,
  input  logic [CHANELS*S_WIDTH-1:0]   core_im_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [CHANELS*S_WIDTH-1:0]   m_re_o,
  output logic [CHANELS*S_WIDTH-1:0]   m_im_o,
  output logic [15:0]                  frame_cnt_o,
  output logic                         overrun_o,
  output logic                         timeout_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LENGTH - 1);

  // Reject parameter sets that cannot form a valid frame or timeout.
  if (FRAME_LENGTH < 2 || TMO_CYCLES < 1 || CORE_LAT < 0) begin : g_param_check
    $error("fft_frame_ctrl: invalid parameters");
  end

  typedef enum logic {
    ST_RUN,
    ST_WAIT
  } state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   result_take;
  logic   tmo_hit;

  assign accept = s_valid_i && s_ready_o;

  // A result is taken only in WAIT, and only if the buffer is free or is being
  // drained in the same cycle. Any other core_valid_i is an overrun.
  assign result_take = (state_q == ST_WAIT) && core_valid_i &&
                       (!m_valid_o || m_ready_i);

  // State register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A core result takes priority over a timeout that
  // occurs in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (accept && rom_addr_o == LAST_ADDR) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_valid_i || tmo_hit) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Sample path, ROM address, result buffer and status.
  // s_ready_o is registered from the next state, so it stays 0 during reset
  // and rises on the first edge after reset is released.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      s_ready_o    <= 1'b0;
      rom_addr_o   <= '0;
      core_valid_o <= 1'b0;
      core_x_o     <= '0;
      core_first_o <= 1'b0;
      core_last_o  <= 1'b0;
      m_valid_o    <= 1'b0;
      m_re_o       <= '0;
      m_im_o       <= '0;
      frame_cnt_o  <= '0;
      overrun_o    <= 1'b0;
    end else begin
      s_ready_o    <= (state_d == ST_RUN);
      core_valid_o <= accept;
      core_first_o <= accept && (rom_addr_o == '0);
      core_last_o  <= accept && (rom_addr_o == LAST_ADDR);

      if (accept) begin
        core_x_o   <= s_x_i;
        rom_addr_o <= (rom_addr_o == LAST_ADDR) ? '0 : rom_addr_o + 1'b1;
      end else if (tmo_hit) begin
        rom_addr_o <= '0;
      end

      if (result_take) begin
        m_valid_o <= 1'b1;
        m_re_o    <= core_re_i;
        m_im_o    <= core_im_i;
      end else if (m_valid_o && m_ready_i) begin
        m_valid_o <= 1'b0;
      end

      if (state_q == ST_WAIT && core_valid_i) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end

      if (core_valid_i && !result_take) begin
        overrun_o <= 1'b1;
      end
    end
  end

`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // The counter reads 0 in the first WAIT cycle. When it reaches
  // TMO_CYCLES-1 without a core result, TMO_CYCLES wait cycles have passed.
  assign tmo_hit = (state_q == ST_WAIT) && !core_valid_i &&
                   (tmo_cnt == TMO_W'(TMO_CYCLES - 1));

  // Wait-cycle counter and sticky timeout flag.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tmo_cnt   <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (state_q == ST_WAIT && state_d == ST_WAIT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      if (tmo_hit) begin
        timeout_o <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl
// Directed bench for fft_frame_ctrl with FRAME_LENGTH=4 and CHANELS=2.
// A stub core sums the samples of each channel over a frame. It returns the
// sums as re and their negation as im, CORE_LAT cycles after the last
// core_valid_o. The expected values are hand-computed constants.
module tb_fft_frame_ctrl;

  localparam int X_WIDTH      = 16;
  localparam int S_WIDTH      = 32;
  localparam int FRAME_LENGTH = 4;
  localparam int CHANELS      = 2;
  localparam int CORE_LAT     = 2;
  localparam int TMO_CYCLES   = 16;

  logic        clk;
  logic        arstn;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] s_x_i;
  logic [1:0]  rom_addr_o;
  logic        core_valid_o;
  logic [31:0] core_x_o;
  logic        core_first_o;
  logic        core_last_o;
  logic        core_valid_i;
  logic [63:0] core_re_i;
  logic [63:0] core_im_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [63:0] m_re_o;
  logic [63:0] m_im_o;
  logic [15:0] frame_cnt_o;
  logic        overrun_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  logic        core_silent = 1'b0;
  logic [1:0]  lat_pipe = '0;
  logic signed [31:0] acc0 = '0;
  logic signed [31:0] acc1 = '0;

  fft_frame_ctrl #(
    .X_WIDTH(X_WIDTH), .S_WIDTH(S_WIDTH), .FRAME_LENGTH(FRAME_LENGTH),
    .CHANELS(CHANELS), .CORE_LAT(CORE_LAT), .TMO_CYCLES(TMO_CYCLES)
  ) dut (
    .clk(clk), .arstn(arstn),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_x_i(s_x_i),
    .rom_addr_o(rom_addr_o),
    .core_valid_o(core_valid_o), .core_x_o(core_x_o),
    .core_first_o(core_first_o), .core_last_o(core_last_o),
    .core_valid_i(core_valid_i), .core_re_i(core_re_i), .core_im_i(core_im_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_re_o(m_re_o), .m_im_o(m_im_o),
    .frame_cnt_o(frame_cnt_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub core: per-channel accumulator. The result pulse is delayed two
  // stages (CORE_LAT) after the last sample.
  always @(posedge clk) begin
    lat_pipe <= {lat_pipe[0], core_valid_o && core_last_o};
    if (core_valid_o) begin
      acc0 <= (core_first_o ? 32'sd0 : acc0) + 32'($signed(core_x_o[15:0]));
      acc1 <= (core_first_o ? 32'sd0 : acc1) + 32'($signed(core_x_o[31:16]));
    end
  end

  assign core_valid_i = lat_pipe[1] && !core_silent;
  assign core_re_i    = {acc1, acc0};
  assign core_im_i    = {-acc1, -acc0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Send one full frame with constant per-channel values. Afterwards, advance
  // to the first cycle after the result lands (three wait cycles).
  task automatic apply_stimulus(input logic [15:0] ch0, input logic [15:0] ch1);
    for (int k = 0; k < FRAME_LENGTH; k++) begin
      s_valid_i = 1'b1;
      s_x_i     = {ch1, ch0};
      tick();
    end
    s_valid_i = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    logic [15:0] t2_ch0 [4];
    logic [15:0] t2_ch1 [4];
    logic        exp_tmo;
    t2_ch0 = '{16'd1, 16'd3, 16'd5, 16'd7};
    t2_ch1 = '{16'd2, 16'd4, 16'd6, 16'd8};
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
    exp_tmo = 1'b1;
`else
    exp_tmo = 1'b0;
`endif

    arstn     = 1'b0;
    s_valid_i = 1'b0;
    s_x_i     = '0;
    m_ready_i = 1'b0;

    // Reset held for 3 cycles, then released.
    repeat (3) tick();
    check_output("rst_addr", 64'(rom_addr_o), 64'd0);
    check_output("rst_ready", 64'(s_ready_o), 64'd0);
    check_output("rst_mvalid", 64'(m_valid_o), 64'd0);
    check_output("rst_cnt", 64'(frame_cnt_o), 64'd0);
    arstn = 1'b1;
    tick();
    check_output("rel_ready", 64'(s_ready_o), 64'd1);
    check_output("rel_addr", 64'(rom_addr_o), 64'd0);

    // Reset asserted mid-frame clears the address without waiting for a clock.
    s_valid_i = 1'b1; s_x_i = {16'd2, 16'd1};
    tick();
    s_x_i = {16'd4, 16'd3};
    tick();
    check_output("mid_addr2", 64'(rom_addr_o), 64'd2);
    s_valid_i = 1'b0;
    arstn = 1'b0;
    #1;
    check_output("mid_rst_addr", 64'(rom_addr_o), 64'd0);
    check_output("mid_rst_ready", 64'(s_ready_o), 64'd0);
    tick();
    arstn = 1'b1;
    tick();
    check_output("mid_rel_ready", 64'(s_ready_o), 64'd1);

    // One frame of (1,2),(3,4),(5,6),(7,8).
    for (int k = 0; k < 4; k++) begin
      s_valid_i = 1'b1;
      s_x_i     = {t2_ch1[k], t2_ch0[k]};
      check_output("f1_addr", 64'(rom_addr_o), 64'(k));
      tick();
      check_output("f1_cvalid", 64'(core_valid_o), 64'd1);
      check_output("f1_cx", 64'(core_x_o), 64'({t2_ch1[k], t2_ch0[k]}));
      check_output("f1_first", 64'(core_first_o), 64'(k == 0));
      check_output("f1_last", 64'(core_last_o), 64'(k == 3));
    end
    s_valid_i = 1'b0;
    check_output("f1_ready_w1", 64'(s_ready_o), 64'd0);
    tick();
    check_output("f1_ready_w2", 64'(s_ready_o), 64'd0);
    check_output("f1_cvalid_idle", 64'(core_valid_o), 64'd0);
    tick();
    check_output("f1_ready_w3", 64'(s_ready_o), 64'd0);
    check_output("f1_mvalid_pre", 64'(m_valid_o), 64'd0);
    tick();
    check_output("f1_ready_back", 64'(s_ready_o), 64'd1);
    check_output("f1_mvalid", 64'(m_valid_o), 64'd1);
    check_output("f1_re", m_re_o, 64'h00000014_00000010);
    check_output("f1_im", m_im_o, 64'hFFFFFFEC_FFFFFFF0);
    check_output("f1_cnt", 64'(frame_cnt_o), 64'd1);
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    check_output("f1_drain", 64'(m_valid_o), 64'd0);

    // s_valid_i toggled 1,0,1,0...: only the accepts advance the address.
    for (int i = 0; i < 8; i++) begin
      s_valid_i = (i % 2 == 0);
      s_x_i     = {16'(20 + i), 16'(10 + i)};
      check_output("tog_addr", 64'(rom_addr_o), 64'(((i + 1) / 2) % 4));
      tick();
      check_output("tog_cvalid", 64'(core_valid_o), 64'(i % 2 == 0));
    end
    s_valid_i = 1'b0;
    repeat (2) tick();
    check_output("tog_mvalid", 64'(m_valid_o), 64'd1);
    check_output("tog_re", m_re_o, 64'h0000005C_00000034);
    check_output("tog_cnt", 64'(frame_cnt_o), 64'd2);
    check_output("tog_ready", 64'(s_ready_o), 64'd1);
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;

    // m_ready_i held low across two frames: the second result is dropped.
    apply_stimulus(16'd1, 16'd1);
    check_output("ov1_re", m_re_o, 64'h00000004_00000004);
    check_output("ov1_over", 64'(overrun_o), 64'd0);
    check_output("ov1_cnt", 64'(frame_cnt_o), 64'd3);
    apply_stimulus(16'd2, 16'd2);
    check_output("ov2_mvalid", 64'(m_valid_o), 64'd1);
    check_output("ov2_re_held", m_re_o, 64'h00000004_00000004);
    check_output("ov2_over", 64'(overrun_o), 64'd1);
    check_output("ov2_cnt", 64'(frame_cnt_o), 64'd4);
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    check_output("ov_drain", 64'(m_valid_o), 64'd0);
    tick();
    check_output("ov_drain_hold", 64'(m_valid_o), 64'd0);

    // Reset clears the sticky flags, the buffer and the frame count.
    arstn = 1'b0;
    #1;
    check_output("r2_over", 64'(overrun_o), 64'd0);
    tick();
    arstn = 1'b1;
    tick();
    check_output("r2_cnt", 64'(frame_cnt_o), 64'd0);
    check_output("r2_mvalid", 64'(m_valid_o), 64'd0);

    // Full buffer drained in the same cycle a new result arrives: no overrun.
    apply_stimulus(16'd3, 16'd3);
    check_output("rep1_re", m_re_o, 64'h0000000C_0000000C);
    for (int k = 0; k < 4; k++) begin
      s_valid_i = 1'b1;
      s_x_i     = {16'd5, 16'd5};
      tick();
    end
    s_valid_i = 1'b0;
    repeat (2) tick();
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    check_output("rep2_mvalid", 64'(m_valid_o), 64'd1);
    check_output("rep2_re", m_re_o, 64'h00000014_00000014);
    check_output("rep2_over", 64'(overrun_o), 64'd0);
    check_output("rep2_cnt", 64'(frame_cnt_o), 64'd2);

    // The core stays silent after a frame.
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    core_silent = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_valid_i = 1'b1;
      s_x_i     = {16'd9, 16'd9};
      tick();
    end
    s_valid_i = 1'b0;
    repeat (15) tick();
    check_output("tmo_pre_ready", 64'(s_ready_o), 64'd0);
    check_output("tmo_pre_flag", 64'(timeout_o), 64'd0);
    tick();
    check_output("tmo_flag", 64'(timeout_o), 64'(exp_tmo));
    check_output("tmo_ready", 64'(s_ready_o), 64'(exp_tmo));
    check_output("tmo_cnt", 64'(frame_cnt_o), 64'd2);
    check_output("tmo_addr", 64'(rom_addr_o), 64'd0);
    check_output("tmo_mvalid", 64'(m_valid_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Frame sequencer for the serial single-bin DFT core (serial_fft_coral) and its twiddle ROMs (RAM_w_re / RAM_w_im).
- Accepts multi-channel samples over a valid/ready stream and drives the ROM address so the twiddle arrives aligned with each sample.
- Marks first and last sample of each frame to the core, waits for the core result, and holds it in a one-deep output buffer with downstream handshake.
- Flags overruns.

Parameters:
- X_WIDTH, 16, per-channel sample width (signed)
- S_WIDTH, 32, per-channel result width (signed)
- FRAME_LENGTH, 10, samples per frame (≥2)
- CHANELS, 2, parallel channels
- CORE_LAT, 2, cycles from last core_valid_o to expected core_valid_i
- TMO_CYCLES, 16, timeout limit in WAIT (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- arstn  in  1  asynchronous reset, active-low
- s_valid_i  in  1  input sample valid
- s_ready_o  out  1  controller can accept a sample
- s_x_i  in  CHANELS*X_WIDTH  packed samples, channel 0 in LSBs
- rom_addr_o  out  $clog2(FRAME_LENGTH)  twiddle ROM address (both ROMs)
- core_valid_o  out  1  sample valid to core
- core_x_o  out  CHANELS*X_WIDTH  registered sample to core
- core_first_o  out  1  first sample of frame (core clears accumulators)
- core_last_o  out  1  last sample of frame
- core_valid_i  in  1  core result valid pulse
- core_re_i, core_im_i  in  CHANELS*S_WIDTH each  core result
- m_valid_o  out  1  result buffer valid
- m_ready_i  in  1  downstream accepts result
- m_re_o, m_im_o  out  CHANELS*S_WIDTH each  buffered result
- frame_cnt_o  out  16  completed frames, wraps at 0xFFFF→0
- overrun_o  out  1  sticky: result lost
- timeout_o  out  1  sticky: core did not respond (0 when feature is off)

Behaviour:
- Reset (arstn=0, async): state=RUN, rom_addr_o=0, all outputs 0, s_ready_o=0 while in reset.
- States: RUN, WAIT.

RUN state:
- s_ready_o=1.
- An accept occurs when s_valid_i && s_ready_o.
- On accept of sample k, next cycle: core_x_o<=s_x_i, core_valid_o=1, core_first_o=(k==0), core_last_o=(k==FRAME_LENGTH-1).
- rom_addr_o equals k during the accept cycle, so the 1-cycle-latency ROM presents w[k] together with core_x_o.
- On accept, rom_addr_o increments and wraps FRAME_LENGTH-1→0.
- Without an accept, core_valid_o/first/last=0 and core_x_o holds.
- After accepting k=FRAME_LENGTH-1, go to WAIT.

WAIT state:
- s_ready_o=0.
- On core_valid_i: go to RUN and increment frame_cnt_o.
- If buffer empty, or m_ready_i is 1 that same cycle: capture core_re_i/core_im_i, m_valid_o=1.
- Otherwise: result dropped, old buffer content kept, overrun_o<=1.
- core_valid_i outside WAIT: ignored, overrun_o<=1.

Output buffer:
- m_valid_o falls the cycle after m_valid_o && m_ready_i, unless refilled the same cycle.
- m_re_o/m_im_o stay stable while m_valid_o && !m_ready_i.

Other rules:
- Back-to-back frames: minimum gap between frames is CORE_LAT+1 cycles, set by WAIT. The first sample of the next frame is accepted the cycle after core_valid_i.
- No arithmetic on data; widths pass through unchanged.
- Reset mid-frame: partial frame discarded, rom_addr_o=0, sticky flags cleared, buffer emptied.

Optional Feature:
- Macro: FFT_FRAME_CTRL_TIMEOUT_EN.
- When defined: a WAIT cycle counter starts at 0 on WAIT entry. If it reaches TMO_CYCLES without core_valid_i, set timeout_o=1 (sticky), return to RUN with rom_addr_o=0, and leave frame_cnt_o unchanged.
- When undefined: no counter, WAIT holds indefinitely, timeout_o tied to 0.

Test Plan:
1. Reset held 3 cycles, then released → rom_addr_o=0, s_ready_o=1 next cycle, m_valid_o=0, frame_cnt_o=0. A second reset asserted mid-frame (after 2 samples) clears rom_addr_o to 0 immediately.
2. FRAME_LENGTH=4, CHANELS=2; samples (ch0,ch1)=(1,2),(3,4),(5,6),(7,8) on consecutive cycles; stub core returns re = per-channel sum after CORE_LAT=2 →
   - rom_addr_o sequence 0,1,2,3 at the accepts
   - core_first_o on (1,2), core_last_o on (7,8)
   - s_ready_o=0 for 3 cycles
   - m_re_o={20,16}, m_valid_o=1, frame_cnt_o=1
3. s_valid_i toggled 1,0,1,0… over one frame → rom_addr_o advances only on accepts, core_valid_o pulses match accepts, 4 accepts complete the frame.
4. m_ready_i=0 across two frames → first result held unchanged, second dropped, overrun_o=1, frame_cnt_o=2. Raising m_ready_i drains one result, then m_valid_o=0.
5. m_ready_i=1 on the same cycle core_valid_i returns with buffer full → new result replaces old, overrun_o stays 0.
6. With FFT_FRAME_CTRL_TIMEOUT_EN, TMO_CYCLES=16, stub core silent → timeout_o=1 after 16 WAIT cycles, s_ready_o=1 next cycle, frame_cnt_o unchanged. Without the macro → s_ready_o stays 0 and timeout_o=0.
